// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and SDRAM-side Avalon-MM signals around the arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
interface mem_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 32,
   parameter int DW      = 32
);
   logic [NUM_REQ*AW-1:0] r_address;
   logic [NUM_REQ-1:0]    r_read;
   logic [NUM_REQ-1:0]    r_write;
   logic [NUM_REQ*DW-1:0] r_writedata;
   logic [NUM_REQ-1:0]    r_lock;
   logic [NUM_REQ-1:0]    r_waitrequest;
   logic [DW-1:0]         r_readdata;
   logic [NUM_REQ-1:0]    r_readdatavalid;

   logic [AW-1:0]         m_address;
   logic                  m_read;
   logic                  m_write;
   logic [DW-1:0]         m_writedata;
   logic                  m_waitrequest;
   logic                  m_readdatavalid;
   logic [DW-1:0]         m_readdata;

   logic                  busy;

   modport master (
      input  r_address, r_read, r_write, r_writedata, r_lock,
      input  m_waitrequest, m_readdatavalid, m_readdata,
      output r_waitrequest, r_readdata, r_readdatavalid,
      output m_address, m_read, m_write, m_writedata, busy
   );

   modport slave (
      output r_address, r_read, r_write, r_writedata, r_lock,
      output m_waitrequest, m_readdatavalid, m_readdata,
      input  r_waitrequest, r_readdata, r_readdatavalid,
      input  m_address, m_read, m_write, m_writedata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with lock override sharing one SDRAM Avalon-MM master
// among NUM_REQ requesters, one outstanding transaction at a time.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no transaction; pick a winner when any request is pending
//   ISSUE   | latched command on m_*; waiting for m_waitrequest to drop
//   WAIT_RD | read accepted; waiting for m_readdatavalid
module mem_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic                clk,
   input  logic                rst,
   mem_arbiter_if.master       bus
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

   state_t              state_q;
   logic [GW-1:0]       grant_q;
   logic [GW-1:0]       last_grant_q;
   logic [GW-1:0]       lock_id_q;
   logic                lock_hold_q;
   logic                m_read_q;
   logic                m_write_q;
   logic [AW-1:0]       addr_q;
   logic [DW-1:0]       wdata_q;

   logic [NUM_REQ-1:0]  pending;
   logic [GW-1:0]       win_d;
   logic [GW:0]         sum;
   logic                found;
   logic [NUM_REQ-1:0]  r_waitreq_c;
   logic [NUM_REQ-1:0]  r_rdvalid_c;

   assign pending = bus.r_read | bus.r_write;

   // Round-robin search starting just after the last completed grant.
   always_comb begin
      win_d = last_grant_q;
      found = 1'b0;
      sum   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = {1'b0, last_grant_q} + (GW+1)'(k);
         if (sum >= (GW+1)'(NUM_REQ)) sum = sum - (GW+1)'(NUM_REQ);
         if (!found && pending[sum[GW-1:0]]) begin
            found = 1'b1;
            win_d = sum[GW-1:0];
         end
      end
      if (lock_hold_q && pending[lock_id_q]) win_d = lock_id_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_REQ-1);
         lock_id_q    <= '0;
         lock_hold_q  <= 1'b0;
         m_read_q     <= 1'b0;
         m_write_q    <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|pending) begin
                  grant_q   <= win_d;
                  addr_q    <= bus.r_address[int'(win_d)*AW +: AW];
                  wdata_q   <= bus.r_writedata[int'(win_d)*DW +: DW];
                  m_write_q <= bus.r_write[win_d];
                  m_read_q  <= ~bus.r_write[win_d];
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               if (!bus.m_waitrequest) begin
                  m_read_q  <= 1'b0;
                  m_write_q <= 1'b0;
                  if (m_write_q) begin
                     last_grant_q <= grant_q;
                     lock_hold_q  <= bus.r_lock[grant_q];
                     lock_id_q    <= grant_q;
                     state_q      <= IDLE;
                  end else begin
                     state_q      <= WAIT_RD;
                  end
               end
            end
            WAIT_RD: begin
               if (bus.m_readdatavalid) begin
                  last_grant_q <= grant_q;
                  lock_hold_q  <= bus.r_lock[grant_q];
                  lock_id_q    <= grant_q;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Accept and read-data strobes must follow the SDRAM in the same cycle.
   always_comb begin
      r_waitreq_c = '1;
      r_rdvalid_c = '0;
      if (state_q == ISSUE && !bus.m_waitrequest) r_waitreq_c[grant_q] = 1'b0;
      if (state_q == WAIT_RD) r_rdvalid_c[grant_q] = bus.m_readdatavalid;
   end

   assign bus.r_waitrequest   = r_waitreq_c;
   assign bus.r_readdatavalid = r_rdvalid_c;
   assign bus.r_readdata      = bus.m_readdata;
   assign bus.m_address       = addr_q;
   assign bus.m_writedata     = wdata_q;
   assign bus.m_read          = m_read_q;
   assign bus.m_write         = m_write_q;
   assign bus.busy            = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven at falling edge, outputs
// sampled 1 time unit later, so each loop iteration is one arbiter cycle.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   mem_arbiter_if #(.NUM_REQ(4), .AW(32), .DW(32)) bus ();

   mem_arbiter #(.NUM_REQ(4), .AW(32), .DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      bus.r_address       = '0;
      bus.r_read          = '0;
      bus.r_write         = '0;
      bus.r_writedata     = '0;
      bus.r_lock          = '0;
      bus.m_waitrequest   = 1'b0;
      bus.m_readdatavalid = 1'b0;
      bus.m_readdata      = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      bus.m_readdata = 32'h1234_5678;
      #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.m_read !== 1'b0 || bus.m_write !== 1'b0) begin failures++; $display("FAIL reset_mcmd got=%b%b exp=00", bus.m_read, bus.m_write); end
      checks++; if (bus.m_address !== 32'h0 || bus.m_writedata !== 32'h0) begin failures++; $display("FAIL reset_maddr got=%h/%h exp=0/0", bus.m_address, bus.m_writedata); end
      checks++; if (bus.r_waitrequest !== 4'hF) begin failures++; $display("FAIL reset_waitreq got=%b exp=1111", bus.r_waitrequest); end
      checks++; if (bus.r_readdatavalid !== 4'h0) begin failures++; $display("FAIL reset_rdvalid got=%b exp=0000", bus.r_readdatavalid); end
      checks++; if (bus.r_readdata !== 32'h1234_5678) begin failures++; $display("FAIL readdata_copy got=%h exp=12345678", bus.r_readdata); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_write();
      do_reset();
      @(negedge clk);
      bus.r_write[2] = 1'b1;
      bus.r_address[2*32 +: 32]   = 32'h40;
      bus.r_writedata[2*32 +: 32] = 32'hA5;
      #1;
      checks++; if (bus.m_write !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL sw_idle got m_write=%b busy=%b exp=0/0", bus.m_write, bus.busy); end
      @(negedge clk); #1;
      checks++; if (bus.m_write !== 1'b1 || bus.m_read !== 1'b0) begin failures++; $display("FAIL sw_mwrite got=%b%b exp rd/wr=01", bus.m_read, bus.m_write); end
      checks++; if (bus.m_address !== 32'h40 || bus.m_writedata !== 32'hA5) begin failures++; $display("FAIL sw_addr_data got=%h/%h exp=40/a5", bus.m_address, bus.m_writedata); end
      checks++; if (bus.r_waitrequest !== 4'b1011) begin failures++; $display("FAIL sw_waitreq got=%b exp=1011", bus.r_waitrequest); end
      @(negedge clk);
      bus.r_write[2] = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.m_write !== 1'b0) begin failures++; $display("FAIL sw_done got busy=%b m_write=%b exp=0/0", bus.busy, bus.m_write); end
   endtask

   task automatic test_write_wins();
      do_reset();
      @(negedge clk);
      bus.r_read[0] = 1'b1;
      bus.r_write[0] = 1'b1;
      bus.r_address[31:0]   = 32'h50;
      bus.r_writedata[31:0] = 32'h99;
      @(negedge clk); #1;
      checks++; if (bus.m_write !== 1'b1 || bus.m_read !== 1'b0) begin failures++; $display("FAIL ww_cmd got rd/wr=%b%b exp=01", bus.m_read, bus.m_write); end
      @(negedge clk);
      bus.r_read[0] = 1'b0;
      bus.r_write[0] = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); #1;
         checks++; if (bus.busy !== 1'b0 || bus.m_read !== 1'b0) begin failures++; $display("FAIL ww_no_read cyc=%0d got busy=%b m_read=%b exp=0/0", c, bus.busy, bus.m_read); end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] acc, acc_prev;
      int who[4];
      int at[4];
      int n;
      do_reset();
      acc_prev = '0;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (c == 0) begin
            for (int i = 0; i < 4; i++) begin
               bus.r_write[i] = 1'b1;
               bus.r_address[i*32 +: 32]   = 32'h100 + 32'(i);
               bus.r_writedata[i*32 +: 32] = 32'hD0 + 32'(i);
            end
         end
         for (int i = 0; i < 4; i++) if (acc_prev[i]) bus.r_write[i] = 1'b0;
         #1;
         acc = ~bus.r_waitrequest;
         if (bus.m_write && acc != 4'b0) begin
            if (n < 4) begin
               who[n] = int'(bus.m_address) - 32'h100;
               at[n]  = c;
            end
            n++;
         end
         acc_prev = acc;
      end
      checks++; if (n != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", n); end
      for (int k = 0; k < 4 && k < n; k++) begin
         checks++; if (who[k] != k) begin failures++; $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", k, who[k], k); end
         checks++; if (at[k] != 1 + 2*k) begin failures++; $display("FAIL b2b_cycle idx=%0d got=%0d exp=%0d", k, at[k], 1 + 2*k); end
      end
   endtask

   task automatic test_lock();
      logic [3:0] acc, acc_prev;
      int cnt1, ng, n1_before3;
      bit seen3;
      do_reset();
      acc_prev = '0;
      cnt1 = 0; ng = 0; n1_before3 = 0; seen3 = 1'b0;
      for (int c = 0; c < 400 && ng < 65; c++) begin
         @(negedge clk);
         if (c == 0) begin
            bus.r_write[1] = 1'b1; bus.r_lock[1] = 1'b1;
            bus.r_address[1*32 +: 32] = 32'h200; bus.r_writedata[1*32 +: 32] = 32'h0;
            bus.r_write[3] = 1'b1; bus.r_lock[3] = 1'b0;
            bus.r_address[3*32 +: 32] = 32'h300; bus.r_writedata[3*32 +: 32] = 32'h3333;
         end
         if (acc_prev[1]) begin
            cnt1++;
            if (cnt1 == 64) begin
               bus.r_write[1] = 1'b0; bus.r_lock[1] = 1'b0;
            end else begin
               bus.r_address[1*32 +: 32]   = 32'h200 + 32'(cnt1);
               bus.r_writedata[1*32 +: 32] = 32'(cnt1);
            end
         end
         if (acc_prev[3]) bus.r_write[3] = 1'b0;
         #1;
         acc = ~bus.r_waitrequest;
         if (acc[1]) begin
            ng++;
            if (!seen3) n1_before3++;
            checks++; if (bus.m_writedata !== 32'(cnt1)) begin failures++; $display("FAIL lock_data got=%h exp=%h", bus.m_writedata, 32'(cnt1)); end
         end
         if (acc[3]) begin
            ng++;
            seen3 = 1'b1;
            checks++; if (bus.m_address !== 32'h300) begin failures++; $display("FAIL lock_req3_addr got=%h exp=300", bus.m_address); end
         end
         acc_prev = acc;
      end
      checks++; if (ng != 65) begin failures++; $display("FAIL lock_total got=%0d exp=65", ng); end
      checks++; if (n1_before3 != 64) begin failures++; $display("FAIL lock_req1_first got=%0d exp=64", n1_before3); end
      checks++; if (seen3 !== 1'b1) begin failures++; $display("FAIL lock_req3_served got=%b exp=1", seen3); end
   endtask

   task automatic test_read_stall();
      int pulses, others;
      do_reset();
      pulses = 0; others = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         case (c)
            0: begin
               bus.r_read[0] = 1'b1; bus.r_address[0*32 +: 32] = 32'h10;
               bus.r_read[2] = 1'b1; bus.r_address[2*32 +: 32] = 32'h20;
               bus.m_waitrequest = 1'b1;
            end
            2: begin bus.m_readdatavalid = 1'b1; bus.m_readdata = 32'h77; end
            3: bus.m_readdatavalid = 1'b0;
            4: bus.m_waitrequest = 1'b0;
            5: begin bus.r_read[0] = 1'b0; bus.m_waitrequest = 1'b1; end
            6: begin bus.m_readdatavalid = 1'b1; bus.m_readdata = 32'h3C; end
            7: begin bus.m_readdatavalid = 1'b0; bus.m_waitrequest = 1'b0; end
            default: ;
         endcase
         #1;
         if (bus.r_readdatavalid[0]) begin
            pulses++;
            checks++; if (bus.r_readdata !== 32'h3C) begin failures++; $display("FAIL rd_data cyc=%0d got=%h exp=3c", c, bus.r_readdata); end
         end
         if (bus.r_readdatavalid[3:1] != 3'b0) others++;
         if (c >= 1 && c <= 3) begin
            checks++; if (bus.m_read !== 1'b1 || bus.m_address !== 32'h10) begin failures++; $display("FAIL rd_stall cyc=%0d got m_read=%b addr=%h exp=1/10", c, bus.m_read, bus.m_address); end
            checks++; if (bus.r_waitrequest !== 4'hF) begin failures++; $display("FAIL rd_stall_wait cyc=%0d got=%b exp=1111", c, bus.r_waitrequest); end
         end
         if (c == 4) begin
            checks++; if (bus.r_waitrequest !== 4'b1110 || bus.m_read !== 1'b1) begin failures++; $display("FAIL rd_accept got wait=%b m_read=%b exp=1110/1", bus.r_waitrequest, bus.m_read); end
         end
         if (c == 5) begin
            checks++; if (bus.m_read !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL rd_waitrd got m_read=%b busy=%b exp=0/1", bus.m_read, bus.busy); end
         end
         if (c == 6) begin
            checks++; if (bus.r_readdatavalid !== 4'b0001) begin failures++; $display("FAIL rd_valid got=%b exp=0001", bus.r_readdatavalid); end
         end
         if (c == 8) begin
            checks++; if (bus.m_read !== 1'b1 || bus.m_address !== 32'h20) begin failures++; $display("FAIL rd_next_req2 got m_read=%b addr=%h exp=1/20", bus.m_read, bus.m_address); end
         end
      end
      checks++; if (pulses != 1) begin failures++; $display("FAIL rd_pulse_count got=%0d exp=1", pulses); end
      checks++; if (others != 0) begin failures++; $display("FAIL rd_other_valid got=%0d exp=0", others); end
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      @(negedge clk);
      bus.r_read[1] = 1'b1;
      bus.r_address[1*32 +: 32] = 32'h30;
      @(negedge clk); #1;
      checks++; if (bus.m_read !== 1'b1 || bus.r_waitrequest !== 4'b1101) begin failures++; $display("FAIL mr_accept got m_read=%b wait=%b exp=1/1101", bus.m_read, bus.r_waitrequest); end
      @(negedge clk);
      bus.r_read[1] = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mr_waitrd_busy got=%b exp=1", bus.busy); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.m_read !== 1'b0) begin failures++; $display("FAIL mr_async got busy=%b m_read=%b exp=0/0", bus.busy, bus.m_read); end
      checks++; if (bus.m_address !== 32'h0) begin failures++; $display("FAIL mr_addr_clear got=%h exp=0", bus.m_address); end
      @(negedge clk);
      rst = 1'b0;
      bus.m_readdatavalid = 1'b1;
      bus.m_readdata = 32'hEE;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (bus.r_readdatavalid !== 4'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL mr_late_valid cyc=%0d got rdv=%b busy=%b exp=0000/0", c, bus.r_readdatavalid, bus.busy); end
         @(negedge clk);
      end
      bus.m_readdatavalid = 1'b0;
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_write();
      test_write_wins();
      test_back_to_back();
      test_lock();
      test_read_stall();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of move-generator requester ports sharing one SDRAM master (pawn, rook, bishop, queen).
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 r_address  in  NUM_REQ*AW  per-requester address; slice i belongs to requester i.
REQ-007 r_read  in  NUM_REQ  per-requester read request.
REQ-008 r_write  in  NUM_REQ  per-requester write request.
REQ-009 r_writedata  in  NUM_REQ*DW  per-requester write data.
REQ-010 r_lock  in  NUM_REQ  requester asks to keep the grant after its current transaction.
REQ-011 r_waitrequest  out  NUM_REQ  per-requester stall; bit low only in the cycle that requester's command is accepted.
REQ-012 r_readdata  out  DW  shared read data, copy of m_readdata.
REQ-013 r_readdatavalid  out  NUM_REQ  per-requester read-data strobe.
REQ-014 m_address / m_read / m_write / m_writedata  out  AW/1/1/DW  Avalon-MM master to SDRAM.
REQ-015 m_waitrequest, m_readdatavalid, m_readdata  in  1/1/DW  Avalon-MM master responses.
REQ-016 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT_RD. At most one outstanding transaction.
REQ-018 IDLE: requester i is pending when r_read[i] or r_write[i] is high.
REQ-019 IDLE, at least one request pending: select a winner, latch its address, writedata and command into registers, go to ISSUE next cycle.
REQ-020 Winner selection: round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-021 Lock override: if lock_hold is set and the locked requester is pending, it wins regardless of round-robin.
REQ-022 Simultaneous r_read and r_write on one requester: write wins; read is ignored for that transaction.
REQ-023 ISSUE: m_address, m_writedata, m_read and m_write are driven only from the latched registers; m_read/m_write are low in every other state.
REQ-024 ISSUE with m_waitrequest=1: hold all m_* outputs unchanged; all r_waitrequest bits stay high.
REQ-025 ISSUE, write accepted (m_waitrequest=0): r_waitrequest[grant]=0 that same cycle (combinational); update last_grant=grant; go to IDLE.
REQ-026 ISSUE, read accepted (m_waitrequest=0): r_waitrequest[grant]=0 that same cycle; go to WAIT_RD.
REQ-027 WAIT_RD: r_readdatavalid[grant] = m_readdatavalid (combinational).
REQ-028 WAIT_RD, on m_readdatavalid=1: update last_grant; go to IDLE.
REQ-029 m_readdatavalid is ignored outside WAIT_RD.
REQ-030 r_readdatavalid is 0 for every non-granted requester.
REQ-031 At completion (REQ-025 write / REQ-028 read), sample r_lock[grant]: set lock_hold and record the grant if high; clear lock_hold otherwise.
REQ-032 Latency, m_waitrequest=0: request in IDLE cycle N -> m_read/m_write asserted in cycle N+1.
REQ-033 Write throughput: one write per 2 cycles.
REQ-034 Read occupancy: 2 cycles plus SDRAM read latency.
REQ-035 Requesters hold their request until their r_waitrequest bit goes low, per Avalon. A request that drops before it is granted is never issued.
REQ-036 r_readdata = m_readdata at all times.

Reset
REQ-037 Reset (asynchronous, takes effect immediately, including mid-transaction):
- state=IDLE
- m_read=m_write=0; m_address=m_writedata=0
- r_waitrequest all 1; r_readdatavalid all 0; busy=0
- last_grant=NUM_REQ-1, so requester 0 has first priority
- lock_hold=0
REQ-038 A read abandoned by reset is not completed; m_readdatavalid arriving after reset is ignored.

Verification
REQ-039 Single write: req2 writes addr 0x40, data 0xA5, m_waitrequest=0 -> m_write=1 one cycle later with addr 0x40, data 0xA5; r_waitrequest[2] low that cycle; busy low again the next cycle.
REQ-040 Contention: all 4 requesters issue writes simultaneously after reset -> m_write order is 0,1,2,3, one write per 2 cycles.
REQ-041 Lock: req1 issues 64 consecutive writes with r_lock=1 while req3 is pending -> all 64 writes from req1 go out first, then req3 is served.
REQ-042 Read with stall and latency: req0 reads addr 0x10; m_waitrequest high for 3 cycles, readdatavalid 2 cycles after accept with data 0x3C -> m_address stable during the stall; r_readdatavalid[0]=1 with r_readdata=0x3C exactly once; no other requester sees readdatavalid.
REQ-043 Reset mid-read: rst asserted while in WAIT_RD -> busy=0 and m_read=0 immediately; a later m_readdatavalid produces no r_readdatavalid pulse.
